// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with write bypass, zero register, pending scoreboard and post-reset clear sweep
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int AW = 5,
  parameter int NRD = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                init_done,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr
);
  localparam int NREGS = 2**AW;
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [NREGS-1:0] pend_q, pend_d;
  logic [XLEN-1:0] mem [NREGS];
  logic run, wr_ok, alloc_ok;
  assign run = state_q == RUN;
  assign init_done = run;
  assign wr_ok = wr_en && !(ZERO_REG && wr_addr == '0);
  assign alloc_ok = alloc_en && !(ZERO_REG && alloc_addr == '0);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q <= '0;
      pend_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
    end
  end
  // Array has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (!run) mem[cnt_q] <= '0;
    else if (wr_ok) mem[wr_addr] <= wr_data;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    if (!run) begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == '1 ? RUN : INIT;
    end else begin
      if (wr_en) pend_d[wr_addr] = 1'b0;
      if (alloc_ok) pend_d[alloc_addr] = 1'b1;
    end
  end
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic hit, zero;
    assign a = rd_addr[g*AW +: AW];
    assign hit = wr_ok && wr_addr == a;
    assign zero = ZERO_REG && a == '0;
    assign rd_data[g*XLEN +: XLEN] = !run || zero ? '0 : hit ? wr_data : mem[a];
    assign rd_busy[g] = !run || (pend_q[a] && !(wr_en && wr_addr == a));
  end
endmodule
